// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FIFO parameters and sizing helper
// Holds the default data width and depth, the fill-level width helper, and the
// depths used by the transmit and receive FIFO instances.
package uart_pkg;

   localparam int UART_WIDTH         = 8;
   localparam int UART_DEPTH         = 16;
   localparam int UART_TX_FIFO_DEPTH = UART_DEPTH;
   localparam int UART_RX_FIFO_DEPTH = UART_DEPTH;

   // A level counts 0..depth inclusive, so it needs one bit more than an address.
   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: flop-array storage with one write port and one combinational read port
// Ports: clk_i clock; we_i/waddr_i/wdata_i write port; raddr_i/rdata_o asynchronous read port.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH,
   parameter int DEPTH = UART_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock UART data-path FIFO with one-entry mode, flush, level and alarm
// Ports: CLK clock; RST synchronous active-high reset; fifo_en selects the DEPTH-entry FIFO (1)
//   or a one-entry holding register (0); flush discards all contents; wdata/wdata_valid write
//   side; rdata/rdata_valid/rdata_taken first-word fall-through read side; fifo_full, fifo_empty,
//   fifo_level status; overrun_err one-cycle dropped-write pulse; fifo_level_for_alarm/fifo_alarm
//   low-level alarm; peak_level high-water mark.
// Optional feature: define UART_FIFO_PEAK_EN to add the peak_level port and register.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_WIDTH,
   parameter int DEPTH = UART_DEPTH
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       fifo_en,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       wdata_valid,
   output logic                       fifo_full,
   output logic                       fifo_empty,
   output logic [lvl_w(DEPTH)-1:0]    fifo_level,
   output logic                       overrun_err,
   input  logic [$clog2(DEPTH)-1:0]   fifo_level_for_alarm,
   output logic                       fifo_alarm,
   output logic [WIDTH-1:0]           rdata,
   output logic                       rdata_valid,
   input  logic                       rdata_taken
`ifdef UART_FIFO_PEAK_EN
   ,output logic [lvl_w(DEPTH)-1:0]   peak_level
`endif
);

   localparam int LW = lvl_w(DEPTH);
   localparam int AW = LW - 1;

   logic [LW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, cap;
   logic             en_q, ovr_q, ovr_d, do_flush, push, pop, drop, we;
   logic [WIDTH-1:0] mem_rdata;

   // Pointers wrap modulo 2*DEPTH, so their difference is the level across any number of wraps.
   assign fifo_level  = wptr_q - rptr_q;
   assign cap         = en_q ? LW'(DEPTH) : LW'(1);
   assign fifo_full   = fifo_level == cap;
   assign fifo_empty  = fifo_level == '0;
   assign rdata_valid = !fifo_empty;
   assign rdata       = fifo_empty ? '0 : mem_rdata;
   assign overrun_err = ovr_q;
   assign fifo_alarm  = fifo_level <= {1'b0, fifo_level_for_alarm};

   // A mode change invalidates the stored contents, so it flushes like an explicit request.
   assign do_flush = flush | (fifo_en != en_q);
   assign pop      = rdata_taken & rdata_valid;
   assign push     = wdata_valid & (!fifo_full | pop);
   assign drop     = wdata_valid & fifo_full & !pop;
   assign we       = push & !do_flush;

   always_comb begin
      wptr_d = do_flush ? '0 : wptr_q + LW'(push);
      rptr_d = do_flush ? '0 : rptr_q + LW'(pop);
      ovr_d  = !do_flush & drop;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovr_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovr_q  <= ovr_d;
      end
      // Tracks the mode unconditionally so leaving reset never looks like a mode change.
      en_q <= fifo_en;
   end

   uart_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk_i   (CLK),
      .we_i    (we),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (wdata),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (mem_rdata)
   );

`ifdef UART_FIFO_PEAK_EN
   logic [LW-1:0] peak_q, peak_d, level_d;

   always_comb begin
      level_d = wptr_d - rptr_d;
      peak_d  = do_flush ? '0 : (level_d > peak_q ? level_d : peak_q);
   end

   always_ff @(posedge CLK) begin
      if (RST) peak_q <= '0;
      else     peak_q <= peak_d;
   end

   assign peak_level = peak_q;
`endif

endmodule
